// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch slice.
//   fetch_entry_t : one prefetch queue slot, {instr, pc}
//   INSTR_BYTES   : PC increment per sequential fetch
//   NOP_INSTR     : canonical RISC-V nop (addi x0,x0,0), used as fill data
package fetch_pkg;

  // Widest PC the queue storage carries; fetch_prefetch Nbits must not exceed it.
  localparam int FETCH_NBITS = 64;

  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]            instr;
    logic [FETCH_NBITS-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_if.sv
// fetch_prefetch_if: bus bundle around the fetch stage.
//   imem_req/imem_addr/imem_rdata : instruction memory read port, data one cycle after req
//   redirect_valid/redirect_pc    : taken-branch redirect from MEM
//   id_valid/id_ready/id_instr/id_pc : decode handshake
// Handshake: a transfer happens in every cycle where id_valid && id_ready are both
// high at the rising edge; while id_valid is high and id_ready low, id_instr/id_pc
// hold their value, and id_valid never drops without a transfer except on redirect
// or reset.
// Modports: master = fetch stage side, slave = memory/decode/branch side.
interface fetch_prefetch_if #(
  parameter int Nbits = 64
);
  logic             imem_req;
  logic [Nbits-1:0] imem_addr;
  logic [31:0]      imem_rdata;
  logic             redirect_valid;
  logic [Nbits-1:0] redirect_pc;
  logic             id_valid;
  logic             id_ready;
  logic [31:0]      id_instr;
  logic [Nbits-1:0] id_pc;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc,
    input  imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc,
    output imem_rdata, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of fetch_entry_t.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : empty the queue at this edge (overrides push/pop)
//   push/pushEntry : write one entry at the tail (caller never pushes when full)
//   pop        : retire the head (caller never pops when empty)
//   headEntry  : combinational view of the head slot
//   count      : occupancy, 0..DEPTH
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             pushEntry,
  input  logic                     pop,
  output fetch_entry_t             headEntry,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] rdPtr;
  logic [AW-1:0] wrPtr;
  fetch_entry_t  mem [DEPTH];

  assign headEntry = mem[rdPtr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem[wrPtr] <= pushEntry;
  end

endmodule

// File: rtl/fetch_prefetch.sv
// fetch_prefetch: instruction fetch stage with prefetch queue.
// Owns the PC, issues sequential word reads, buffers returned words with their PC
// and hands them to decode; a branch redirect flushes and restarts at the target.
//   clk, rst      : clock, synchronous active-high reset
//   bus (master)  : imem read port, redirect input, decode valid/ready handshake
//   perf_issued   : handshakes to decode (only with FETCH_PERF_EN)
//   perf_stall    : cycles with id_valid && !id_ready (only with FETCH_PERF_EN)
// Optional build macro: FETCH_PERF_EN adds the two 32-bit wrapping perf counters.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int               Nbits    = 64,
  parameter int               DEPTH    = 4,
  parameter logic [Nbits-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  fetch_prefetch_if.master  bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_issued,
  output logic [31:0]       perf_stall
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [Nbits-1:0] pc;
  logic [Nbits-1:0] inflightPc;
  logic             inflight;
  logic             discard;
  logic [CW-1:0]    count;
  logic [CW:0]      used;
  logic             issue;
  logic             push;
  logic             pop;
  logic             idValid;
  fetch_entry_t     pushEntry;
  fetch_entry_t     headEntry;

  // Credit check: queued words plus the one in flight must leave room, so a
  // returning word always has a free slot.
  assign used  = {1'b0, count} + (CW+1)'(inflight);
  assign issue = !rst && !bus.redirect_valid && (used < (CW+1)'(DEPTH));

  assign idValid = !rst && (count != '0);
  assign pop     = idValid && bus.id_ready;
  assign push    = !rst && inflight && !discard;

  assign pushEntry.instr = bus.imem_rdata;
  assign pushEntry.pc    = FETCH_NBITS'(inflightPc);

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc;
  assign bus.id_valid  = idValid;
  assign bus.id_instr  = headEntry.instr;
  assign bus.id_pc     = Nbits'(headEntry.pc);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      inflight   <= 1'b0;
      inflightPc <= '0;
      discard    <= 1'b0;
    end else if (bus.redirect_valid) begin
      // Targets are forced to word alignment. No request issues while redirect
      // is high, so nothing issued before the redirect can return afterwards and
      // discard stays clear; a word returning this cycle is flushed with the queue.
      pc       <= bus.redirect_pc & ~Nbits'(INSTR_BYTES - 1);
      inflight <= 1'b0;
      discard  <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc         <= pc + Nbits'(INSTR_BYTES);
        inflightPc <= pc;
      end
      if (inflight && discard) discard <= 1'b0;
    end
  end

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect_valid),
    .push      (push),
    .pushEntry (pushEntry),
    .pop       (pop),
    .headEntry (headEntry),
    .count     (count)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (pop)                      perf_issued <= perf_issued + 32'd1;
      if (idValid && !bus.id_ready) perf_stall  <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_prefetch.md
# fetch_prefetch

Instruction fetch stage with a small prefetch queue. It sits directly upstream of the IF/ID pipeline buffer in the multicycle RISC-V core. It owns the program counter, issues sequential reads to the instruction memory and buffers the returned words with their PCs. It presents them to decode through a valid/ready handshake, and flushes and restarts on a branch redirect from the MEM stage.

## Interface
- Parameters
  - `Nbits`, 64: PC/address width.
  - `DEPTH`, 4: prefetch queue entries; must be a power of two and at least 2.
  - `RESET_PC`, 0: PC loaded on reset.
- Ports (one clock; reset is synchronous and active-high)
  - `clk`: input, 1. Rising-edge clock.
  - `rst`: input, 1. Synchronous, active-high reset.
  - `imem_req`: output, 1. Read request to instruction memory.
  - `imem_addr`: output, Nbits. Read address, byte address, word aligned.
  - `imem_rdata`: input, 32. Instruction word, valid in the cycle after `imem_req`.
  - `redirect_valid`: input, 1. Taken branch; equals `ZeroMEM & branchMEM`.
  - `redirect_pc`: input, Nbits. Branch target.
  - `id_valid`: output, 1. Queue head holds an instruction.
  - `id_ready`: input, 1. Decode accepts the head this cycle.
  - `id_instr`: output, 32. Head instruction.
  - `id_pc`: output, Nbits. PC of the head instruction.
  - `perf_issued`: output, 32. Present only with `FETCH_PERF_EN`.
  - `perf_stall`: output, 32. Present only with `FETCH_PERF_EN`.

## Operation
- **State**
  - `pc` register.
  - `inflight` flag (0/1) and `inflight_pc`.
  - `discard` flag.
  - Circular queue of {instr, pc} with `rd_ptr`, `wr_ptr` and a `count` that runs 0..DEPTH.
- **Issue**
  - `imem_req = !rst && !redirect_valid && (count + inflight < DEPTH)`.
  - `imem_addr = pc`.
  - On issue: `pc <= pc + 4`, with modulo 2^Nbits wrap-around. Also `inflight <= 1` and `inflight_pc <= pc`.
- **Capture**
  - While `inflight` is set and `discard` is clear, write {`imem_rdata`, `inflight_pc`} at `wr_ptr`.
  - While `inflight` is set and `discard` is set, drop the word and clear `discard`.
  - Because of the credit check, a write never hits a full queue. An overflow is a bug; the bench asserts it never happens.
- **Dequeue**
  - `id_valid = (count != 0)`.
  - `id_instr` and `id_pc` are driven combinationally from the head entry.
  - Handshake occurs when `id_valid && id_ready`; `rd_ptr` advances.
  - `id_instr` and `id_pc` stay stable while `id_valid && !id_ready`.
- **Simultaneous push and pop**: `count` is unchanged and both pointers advance.
- **Redirect** (cycle R)
  - A handshake in cycle R still completes.
  - At the end of R: the queue is emptied (pointers and `count` reset) and `pc <= {redirect_pc[Nbits-1:2], 2'b00}`. Misaligned targets are forced to word alignment.
  - If a word is in flight during cycle R, it is captured as normal only if it was not already issued under a prior redirect; it is then flushed by the same edge.
  - Any request issued in cycle R is impossible, because `imem_req` is low.
  - A redirect on consecutive cycles: the last one wins.
- **Reset**
  - `pc = RESET_PC`; queue empty; `inflight = 0`; `discard = 0`.
  - `id_valid = 0` and `imem_req = 0` while `rst` is high.
  - Reset mid-operation drops all queued and in-flight words.

## Timing
- A request in cycle N returns data in cycle N+1, which is written at the end of N+1. `id_valid` rises in cycle N+2 (2-cycle fetch latency).
- Throughput is 1 instruction/cycle sustained while `id_ready` = 1.
- Reset is released at edge 0:
  - Cycle 0: `imem_req` = 1 with address `RESET_PC`.
  - Cycle 2: `id_valid` = 1.
- Redirect in cycle R:
  - Cycle R+1: `id_valid` = 0 and `imem_req` = 1 with address `redirect_pc`.
  - Cycle R+3: first target instruction valid.
- With decode stalled, the queue fills to DEPTH and `imem_req` drops.
- After `id_ready` returns, a new request issues in the same cycle as the freeing handshake plus 1.

## Configuration
- `FETCH_PERF_EN`
  - Defined:
    - `perf_issued` counts handshakes.
    - `perf_stall` counts cycles with `id_valid && !id_ready`.
    - Both are 32-bit, wrap at 2^32 and are cleared by `rst`.
  - Undefined: both ports and their counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `fetch_pkg`:
  - `fetch_entry_t` struct {instr[31:0], pc[Nbits-1:0]}.
  - Constant `INSTR_BYTES = 4`.
  - Constant `NOP_INSTR = 32'h00000013`, used by the bench for fill.
- One sub-module, `fetch_queue`: parameterised circular FIFO of `fetch_entry_t` with push, pop, flush and count. `fetch_prefetch` holds the PC, the in-flight logic and the perf counters.

## Test plan
- **Reset and stream**: memory returns `instr = addr`; `id_ready` = 1. Expected:
  - `id_valid` rises at cycle 2 with `id_pc` = 0.
  - `id_pc` = 0x4, 0x8, 0xC follow on consecutive cycles.
- **Backpressure**: `id_ready` = 0 from cycle 3.
  - Expected: `count` reaches 4 and `imem_req` = 0; head stays at pc 0x4.
  - Then release: pcs 0x4..0x14 are delivered in order with no gap and no duplicate.
- **Redirect**: `redirect_valid` is held for 1 cycle at R = 6 with `redirect_pc` = 0x100.
  - Expected: `id_valid` = 0 at R+1; `imem_addr` = 0x100 at R+1; first `id_pc` = 0x100 at R+3.
  - No pre-redirect pc appears after R.
- **Redirect with handshake**: a handshake of pc 0x10 and a redirect to 0x40 occur in the same cycle.
  - Expected: 0x10 is consumed exactly once; next delivered pc = 0x40.
  - Repeat with a misaligned target of 0x42; expected `id_pc` = 0x40.
- **Wrap-around**: `RESET_PC` = 2^64−8.
  - Expected `id_pc` sequence: 0xFFFF_FFFF_FFFF_FFF8, 0xFFFF_FFFF_FFFF_FFFC, 0x0.
- **Mid-run reset and perf**: assert `rst` for 1 cycle while the queue is full, with `FETCH_PERF_EN` defined.
  - Expected: `id_valid` = 0 the next cycle; the counters read 0.
  - Restart from `RESET_PC`.
  - After 10 handshakes and 3 stall cycles: `perf_issued` = 10 and `perf_stall` = 3.
